// File: rtl/al_accel_acc_ctrl.sv
// Per-pixel strobe sequencer for the accumulation matrix: REQ -> LOAD -> WRITE -> (WAIT_DI -> SUM) x n -> OUT -> DONE.
// 7 cycles start-to-done at n=1, +2 per extra channel group; out_valid holds until out_ready, enb=0 freezes and zeroes outputs.
module al_accel_acc_ctrl #(
    parameter int CH_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enb,
    input  logic            start,
    input  logic [CH_W-1:0] num_ch,
    input  logic            bps_valid,
    input  logic            di_valid,
    input  logic            out_ready,
    output logic            bps_rd_req,
    output logic            acc_matrix_bps_load,
    output logic            acc_matrix_bps_write,
    output logic            acc_matrix_inter_sum_write,
    output logic            out_valid,
    output logic            busy,
    output logic            done,
    output logic [CH_W-1:0] ch_cnt
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        LOAD    = 3'd2,
        WRITE   = 3'd3,
        WAIT_DI = 3'd4,
        SUM     = 3'd5,
        OUT     = 3'd6,
        DONE    = 3'd7
    } state_t;

    typedef struct packed {
        logic rd_req;
        logic load;
        logic write;
        logic sum;
        logic out;
        logic busy;
        logic done;
    } flags_t;

    state_t          state;
    state_t          state_nxt;
    logic [CH_W-1:0] cnt_q;
    logic [CH_W-1:0] cnt_nxt;
    logic [CH_W-1:0] cnt_inc;
    logic [CH_W-1:0] n_q;
    logic [CH_W-1:0] n_nxt;
    flags_t          flags_q;

    function automatic flags_t decode(input state_t s);
        flags_t f;
        f        = '0;
        f.rd_req = (s == REQ);
        f.load   = (s == LOAD);
        f.write  = (s == WRITE);
        f.sum    = (s == SUM);
        f.out    = (s == OUT);
        f.busy   = (s != IDLE);
        f.done   = (s == DONE);
        return f;
    endfunction

    assign cnt_inc = cnt_q + {{(CH_W-1){1'b0}}, 1'b1};

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_q;
        n_nxt     = n_q;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = REQ;
                    cnt_nxt   = '0;
                    // zero channel groups still produces one accumulation
                    n_nxt     = (num_ch == '0) ? {{(CH_W-1){1'b0}}, 1'b1} : num_ch;
                end
            end
            REQ:     if (bps_valid) state_nxt = LOAD;
            LOAD:    state_nxt = WRITE;
            WRITE:   state_nxt = WAIT_DI;
            WAIT_DI: if (di_valid) state_nxt = SUM;
            SUM: begin
                cnt_nxt   = cnt_inc;
                state_nxt = (cnt_inc == n_q) ? OUT : WAIT_DI;
            end
            OUT:     if (out_ready) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output flags are registered alongside the state so they always match it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt_q   <= '0;
            n_q     <= '0;
            flags_q <= '0;
        end else if (enb) begin
            state   <= state_nxt;
            cnt_q   <= cnt_nxt;
            n_q     <= n_nxt;
            flags_q <= decode(state_nxt);
        end
    end

    assign bps_rd_req                 = enb & flags_q.rd_req;
    assign acc_matrix_bps_load        = enb & flags_q.load;
    assign acc_matrix_bps_write       = enb & flags_q.write;
    assign acc_matrix_inter_sum_write = enb & flags_q.sum;
    assign out_valid                  = enb & flags_q.out;
    assign busy                       = enb & flags_q.busy;
    assign done                       = enb & flags_q.done;
    assign ch_cnt                     = enb ? cnt_q : '0;

endmodule

// File: tb/tb_al_accel_acc_ctrl.sv
// Directed bench for al_accel_acc_ctrl; a scoreboard queue holds the ch_cnt expected at each done pulse.
module tb_al_accel_acc_ctrl;

    localparam int CH_W = 8;

    logic            clk;
    logic            reset;
    logic            enb;
    logic            start;
    logic [CH_W-1:0] num_ch;
    logic            bps_valid;
    logic            di_valid;
    logic            out_ready;
    logic            bps_rd_req;
    logic            load;
    logic            write;
    logic            isw;
    logic            out_valid;
    logic            busy;
    logic            done;
    logic [CH_W-1:0] ch_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];

    al_accel_acc_ctrl #(.CH_W(CH_W)) dut (
        .clk                        (clk),
        .reset                      (reset),
        .enb                        (enb),
        .start                      (start),
        .num_ch                     (num_ch),
        .bps_valid                  (bps_valid),
        .di_valid                   (di_valid),
        .out_ready                  (out_ready),
        .bps_rd_req                 (bps_rd_req),
        .acc_matrix_bps_load        (load),
        .acc_matrix_bps_write       (write),
        .acc_matrix_inter_sum_write (isw),
        .out_valid                  (out_valid),
        .busy                       (busy),
        .done                       (done),
        .ch_cnt                     (ch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] all_out();
        return {bps_rd_req, load, write, isw, out_valid, busy, done};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pixel(input logic [CH_W-1:0] nc, input int exp_cnt);
        num_ch = nc;
        start  = 1'b1;
        exp_q.push_back(exp_cnt);
        step();
        start  = 1'b0;
    endtask

    // Runs from the current observation until done, counting strobes; leaves the bench one cycle past done.
    task automatic run_to_done(input int max_cyc, output int nl, output int nw, output int ns, output int nd);
        nl = 0; nw = 0; ns = 0; nd = 0;
        for (int c = 0; c < max_cyc; c++) begin
            nl += int'(load);
            nw += int'(write);
            ns += int'(isw);
            if (done) begin
                nd++;
                break;
            end
            step();
        end
        step();
    endtask

    // Scoreboard side: every done pulse must have a pending expectation.
    always @(negedge clk) begin
        if (!reset) begin
            check("strobe_exclusive", 32'(($countones({load, write, isw}) <= 1)), 32'd1);
            if (done) begin
                check("done_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) check("ch_cnt_at_done", 32'(ch_cnt), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int nl, nw, ns, nd, cnt_isw, ov_cnt;
        logic prev_di;
        logic got_done;

        reset = 1'b1; enb = 1'b1; start = 1'b0; num_ch = '0;
        bps_valid = 1'b0; di_valid = 1'b0; out_ready = 1'b0;
        #1;
        check("reset_outputs", 32'(all_out()), 32'd0);
        check("reset_ch_cnt", 32'(ch_cnt), 32'd0);
        step(); step();
        reset = 1'b0;
        step();
        check("idle_outputs", 32'(all_out()), 32'd0);

        // Basic pass, n=1, all handshakes tied high
        bps_valid = 1'b1; di_valid = 1'b1; out_ready = 1'b1;
        start_pixel(8'd1, 1);
        for (int c = 1; c <= 8; c++) begin
            check($sformatf("basic_rd_req_c%0d", c), 32'(bps_rd_req), 32'(c == 1));
            check($sformatf("basic_load_c%0d", c), 32'(load), 32'(c == 2));
            check($sformatf("basic_write_c%0d", c), 32'(write), 32'(c == 3));
            check($sformatf("basic_isw_c%0d", c), 32'(isw), 32'(c == 5));
            check($sformatf("basic_ov_c%0d", c), 32'(out_valid), 32'(c == 6));
            check($sformatf("basic_done_c%0d", c), 32'(done), 32'(c == 7));
            check($sformatf("basic_busy_c%0d", c), 32'(busy), 32'(c <= 7));
            if (c < 8) step();
        end

        // Multi-channel, di_valid one cycle in four
        di_valid = 1'b0;
        start_pixel(8'd3, 3);
        cnt_isw = 0; prev_di = 1'b0; got_done = 1'b0;
        for (int c = 0; c < 60 && !got_done; c++) begin
            if (isw) begin
                check("multi_isw_after_di", 32'(prev_di), 32'd1);
                cnt_isw++;
            end
            if (out_valid) check("multi_ov_after_third", 32'(cnt_isw), 32'd3);
            if (done) got_done = 1'b1;
            prev_di  = (c % 4 == 3);
            di_valid = prev_di;
            step();
        end
        check("multi_done_seen", 32'(got_done), 32'd1);
        check("multi_isw_count", 32'(cnt_isw), 32'd3);
        di_valid = 1'b0;
        step();

        // Backpressure on the output handshake
        di_valid = 1'b1; out_ready = 1'b0;
        start_pixel(8'd2, 2);
        for (int c = 0; c < 20 && !out_valid; c++) step();
        check("bp_ov_reached", 32'(out_valid), 32'd1);
        ov_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            ov_cnt += int'(out_valid);
            check("bp_ov_held", 32'(out_valid), 32'd1);
            check("bp_no_done", 32'(done), 32'd0);
            step();
        end
        ov_cnt += int'(out_valid);
        check("bp_ov_cycles", 32'(ov_cnt >= 10), 32'd1);
        out_ready = 1'b1;
        step();
        check("bp_done_after_ready", 32'(done), 32'd1);
        check("bp_ov_dropped", 32'(out_valid), 32'd0);
        check("bp_busy_in_done", 32'(busy), 32'd1);
        step();
        check("bp_busy_falls", 32'(busy), 32'd0);
        check("bp_done_one_cycle", 32'(done), 32'd0);

        // Enable freeze while in WRITE
        start_pixel(8'd1, 1);
        check("frz_req", 32'(bps_rd_req), 32'd1);
        step();
        check("frz_load", 32'(load), 32'd1);
        step();
        enb = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("frz_outputs_zero", 32'(all_out()), 32'd0);
            check("frz_ch_cnt_zero", 32'(ch_cnt), 32'd0);
            step();
        end
        enb = 1'b1;
        #1;
        check("frz_write_resumes", 32'(write), 32'd1);
        check("frz_no_load", 32'(load), 32'd0);
        check("frz_no_isw", 32'(isw), 32'd0);
        step();
        check("frz_write_single", 32'(write), 32'd0);
        run_to_done(20, nl, nw, ns, nd);
        check("frz_rest_load", 32'(nl), 32'd0);
        check("frz_rest_write", 32'(nw), 32'd0);
        check("frz_rest_isw", 32'(ns), 32'd1);
        check("frz_done", 32'(nd), 32'd1);

        // Asynchronous reset in WAIT_DI with one group accumulated
        di_valid = 1'b0;
        start_pixel(8'd2, 2);
        step(); step(); step();
        di_valid = 1'b1;
        step();
        check("rst_isw_first", 32'(isw), 32'd1);
        di_valid = 1'b0;
        step();
        check("rst_pre_ch_cnt", 32'(ch_cnt), 32'd1);
        check("rst_pre_busy", 32'(busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("rst_outputs_now", 32'(all_out()), 32'd0);
        check("rst_ch_cnt_now", 32'(ch_cnt), 32'd0);
        exp_q.delete();
        step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("rst_no_done", 32'(done), 32'd0);
            step();
        end
        di_valid = 1'b1;
        start_pixel(8'd2, 2);
        run_to_done(30, nl, nw, ns, nd);
        check("rst_next_isw", 32'(ns), 32'd2);
        check("rst_next_done", 32'(nd), 32'd1);

        // num_ch = 0 behaves as one group
        start_pixel(8'd0, 1);
        run_to_done(20, nl, nw, ns, nd);
        check("zero_isw", 32'(ns), 32'd1);
        check("zero_done", 32'(nd), 32'd1);

        // start during REQ is ignored
        bps_valid = 1'b0;
        start_pixel(8'd1, 1);
        start = 1'b1;
        step();
        start = 1'b0;
        check("req_start_ignored", 32'(bps_rd_req), 32'd1);
        bps_valid = 1'b1;
        run_to_done(20, nl, nw, ns, nd);
        check("req_single_done", 32'(nd), 32'd1);
        check("req_single_load", 32'(nl), 32'd1);
        for (int i = 0; i < 10; i++) begin
            check("req_no_second_pixel", 32'({busy, done}), 32'd0);
            step();
        end

        // bps_valid held low for 20 cycles
        bps_valid = 1'b0;
        start_pixel(8'd2, 2);
        for (int i = 0; i < 20; i++) begin
            check("stall_rd_req", 32'(bps_rd_req), 32'd1);
            check("stall_no_strobe", 32'({load, write, isw}), 32'd0);
            step();
        end
        bps_valid = 1'b1;
        run_to_done(30, nl, nw, ns, nd);
        check("stall_isw", 32'(ns), 32'd2);
        check("stall_done", 32'(nd), 32'd1);

        step();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
